// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin sequencer sharing a byte-wide instruction memory between fetch and loader.
// Optional build macro IMEM_ALIGN_CHECK_EN rejects misaligned requests with an error completion.
module imem_port_arbiter #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_valid,
    output logic [31:0]       if_data,
    output logic              if_err,
    input  logic              ld_req,
    input  logic [31:0]       ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_done,
    output logic              ld_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_e;

    typedef enum logic {
        GNT_FETCH,
        GNT_LOADER
    } gnt_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    gnt_e              last_gnt_q, last_gnt_d;
    gnt_e              cur_gnt_q, cur_gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       if_data_q, if_data_d;
`ifdef IMEM_ALIGN_CHECK_EN
    logic              err_q, err_d;
`endif

    logic              grant_fetch;
    logic              grant_any;
    logic [31:0]       sel_addr;
    logic [ADDR_W-1:0] beat_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_gnt_q <= GNT_LOADER;
            cur_gnt_q  <= GNT_FETCH;
            base_q     <= '0;
            wdata_q    <= '0;
            if_data_q  <= '0;
`ifdef IMEM_ALIGN_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            cur_gnt_q  <= cur_gnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            if_data_q  <= if_data_d;
`ifdef IMEM_ALIGN_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    // On a tie the requester that was not granted last time wins.
    assign grant_any   = if_req | ld_req;
    assign grant_fetch = if_req & (~ld_req | (last_gnt_q == GNT_LOADER));
    assign sel_addr    = grant_fetch ? if_addr : ld_addr;
    assign beat_addr   = base_q + ADDR_W'(cnt_q);
    assign if_data     = if_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        cur_gnt_d  = cur_gnt_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        if_data_d  = if_data_q;
`ifdef IMEM_ALIGN_CHECK_EN
        err_d      = err_q;
`endif
        if_valid   = 1'b0;
        if_err     = 1'b0;
        ld_done    = 1'b0;
        ld_err     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        busy       = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    cur_gnt_d  = grant_fetch ? GNT_FETCH : GNT_LOADER;
                    last_gnt_d = grant_fetch ? GNT_FETCH : GNT_LOADER;
                    base_d     = sel_addr[ADDR_W-1:0];
                    cnt_d      = '0;
                    if_data_d  = '0;
                    if (!grant_fetch) begin
                        wdata_d = ld_wdata;
                    end
                    state_d    = grant_fetch ? S_FETCH : S_WRITE;
`ifdef IMEM_ALIGN_CHECK_EN
                    err_d      = (sel_addr[1:0] != 2'b00);
                    if (sel_addr[1:0] != 2'b00) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_FETCH: begin
                mem_addr  = beat_addr;
                if_data_d = {if_data_q[23:0], mem_rdata};
                cnt_d     = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                mem_addr = beat_addr;
                // A beat in flight while reset is asserted is not committed to memory.
                mem_we   = rst_n;
                unique case (cnt_q)
                    2'd0:    mem_wdata = wdata_q[31:24];
                    2'd1:    mem_wdata = wdata_q[23:16];
                    2'd2:    mem_wdata = wdata_q[15:8];
                    default: mem_wdata = wdata_q[7:0];
                endcase
                cnt_d    = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (cur_gnt_q == GNT_FETCH) begin
                    if_valid = 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
                    if_err   = err_q;
`endif
                end else begin
                    ld_done  = 1'b1;
`ifdef IMEM_ALIGN_CHECK_EN
                    ld_err   = err_q;
`endif
                end
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Sequencer and arbiter for the byte-wide, single-ported instruction memory. It shares the memory between the instruction-fetch requester and the program-loader requester. Each granted transaction is broken into four byte beats, in big-endian order: the byte at the lowest address is the instruction MSB. Fetches assemble a 32-bit word; loads scatter a 32-bit word into four consecutive bytes.

## Interface
- `ADDR_W`, default 10: memory byte-address width (1024 bytes).
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request, level; held until `if_valid`.
- `if_addr` in 32: fetch byte address; stable while `if_req` is high.
- `if_valid` out 1: one-cycle pulse, fetch complete.
- `if_data` out 32: assembled instruction; meaningful only when `if_valid` is high.
- `if_err` out 1: fetch error, qualified by `if_valid`.
- `ld_req` in 1: loader write request, level; held until `ld_done`.
- `ld_addr` in 32: write byte address; stable while `ld_req` is high.
- `ld_wdata` in 32: write word; stable while `ld_req` is high.
- `ld_done` out 1: one-cycle pulse, write complete.
- `ld_err` out 1: write error, qualified by `ld_done`.
- `mem_addr` out `ADDR_W`: memory byte address.
- `mem_we` out 1: memory byte write enable.
- `mem_wdata` out 8: memory write byte.
- `mem_rdata` in 8: memory read byte, combinational from `mem_addr`.
- `busy` out 1: high in every state other than IDLE.

## Operation
- States: IDLE, FETCH, WRITE, DONE.
- **IDLE**
  - Samples the requests and latches the base address (and `ld_wdata` for a write).
  - Only `if_req` high: go to FETCH.
  - Only `ld_req` high: go to WRITE.
  - Both high: round-robin on `last_gnt`; the requester not granted last time wins. `last_gnt` resets to LOADER, so fetch wins the first tie.
  - Neither high: stay in IDLE.
- **FETCH / WRITE**
  - 2-bit beat counter `cnt` runs 0..3.
  - `mem_addr` = (base + `cnt`) truncated to `ADDR_W`; out-of-range addresses wrap modulo 2^`ADDR_W`.
  - FETCH: shifts `mem_rdata` into `if_data` each beat, MSB first, so beat 0 lands in [31:24].
  - WRITE: `mem_we`=1 and `mem_wdata` = `ld_wdata` byte (3−`cnt`), so beat 0 drives [31:24].
  - After beat 3, go to DONE.
- **DONE**
  - Pulses `if_valid` or `ld_done` (whichever requester was granted) for one cycle, then goes to IDLE.
  - The requester drops its `req` on that edge. A `req` still high in IDLE is treated as a new request.
- Request lines are not re-sampled in FETCH/WRITE. A request that rises mid-transaction waits for IDLE.
- `mem_we` is 0 in every state except WRITE.
- Reset values: state IDLE, `cnt`=0, `last_gnt`=LOADER, and all outputs 0. A reset mid-WRITE leaves any bytes already written in memory; no rollback.

## Timing
- Request seen in IDLE at cycle 0 → beats in cycles 1–4 → `if_valid`/`ld_done` in cycle 5.
- Latency is 5 cycles from request to completion; throughput is 1 transaction per 6 cycles.
- `mem_rdata` is sampled on the same edge that ends each FETCH beat (combinational memory read).
- Back-to-back: the loser of a tie is granted in the IDLE cycle after DONE, i.e. cycle 6.
- `busy` is high in cycles 1–5 and low in IDLE.

## Configuration
- `IMEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a request with address[1:0] ≠ 0 skips the memory beats and goes directly to DONE.
  - DONE asserts `if_err`/`ld_err` together with the completion pulse. `if_data`=0 and no byte is written.
  - Misaligned latency: completion in cycle 1.
- Not defined:
  - No alignment check; `if_err` and `ld_err` are tied to 0.
  - Misaligned addresses run four beats from the unaligned base.

## Test plan
- **Aligned fetch:** memory bytes 4..7 = 00,10,00,93, `if_req` with `if_addr`=0x4 → `if_valid` in cycle 5 with `if_data`=0x00100093, `if_err`=0, `mem_we` never asserted.
- **Loader write:** `ld_addr`=0x20, `ld_wdata`=0xDEADBEEF → bytes 0x20..0x23 = DE,AD,BE,EF on cycles 1–4; `ld_done` in cycle 5; a subsequent fetch of 0x20 returns 0xDEADBEEF.
- **Tie arbitration:** both requests raised in the first cycle after reset → fetch served first (`if_valid` cycle 5), write granted cycle 6 (`ld_done` cycle 11). Repeat the tie → loader served first.
- **Reset mid-write:** `rst_n` low in cycle 3 of a write of 0x11223344 to 0x40 → outputs 0 and IDLE on the next edge; bytes 0x40..0x41 = 11,22, bytes 0x42..0x43 unchanged.
- **Wrap:** fetch at 0x400 with `ADDR_W`=10 → `mem_addr` sequence 0x000..0x003.
- **Misaligned:** `if_addr`=0x6.
  - With `IMEM_ALIGN_CHECK_EN`: `if_valid` with `if_err`=1 and `if_data`=0 in cycle 1.
  - Without it: `mem_addr` sequence 0x6..0x9, `if_valid` in cycle 5.
